// File: rtl/lru_pkg.sv
// Shared defaults and controller state type for the LRU tag controller.
package lru_pkg;

    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned TAG_W_DEFAULT = 20;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StRefill,
        StResp
    } state_e;

endpackage

// File: rtl/lru_tag_cam.sv
// Tag/valid store with fully parallel compare against a single lookup tag.
module lru_tag_cam
    import lru_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_all,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_blk,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [TAG_W-1:0] cmp_tag,
    output logic [DEPTH-1:0] hit_vec,
    output logic             any_hit,
    output logic [DEPTH-1:0] first_inv,
    output logic             any_inv
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tags_q [DEPTH];

    // Valid bits: reset and bulk invalidate clear them, a refill sets one.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q <= valid_q | wr_blk;
        end
    end

    // Tag storage has no reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_blk[i]) begin
                    tags_q[i] <= wr_tag;
                end
            end
        end
    end

    // Parallel compare; invalid entries are masked so they never hit.
    always_comb begin
        hit_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid_q[i] && (tags_q[i] == cmp_tag);
        end
    end

    assign any_hit   = |hit_vec;
    // Isolate the lowest clear bit of the valid vector.
    assign first_inv = ~valid_q & (valid_q + DEPTH'(1));
    assign any_inv   = ~&valid_q;

endmodule

// File: rtl/lru_tag_ctrl.sv
// Fully-associative tag controller: lookup, refill on miss, LRU update strobe.
module lru_tag_ctrl
    import lru_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             inv_all,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [DEPTH-1:0] rsp_blk,
    output logic             refill_req_valid,
    output logic [TAG_W-1:0] refill_req_tag,
    output logic [DEPTH-1:0] refill_req_blk,
    input  logic             refill_ack,
    output logic             lru_update,
    output logic [DEPTH-1:0] lru_accessed_blk,
    input  logic [DEPTH-1:0] lru_victim_blk
);

    state_e           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [DEPTH-1:0] alloc_q, alloc_d;
    logic [DEPTH-1:0] rsp_blk_q, rsp_blk_d;
    logic             rsp_hit_q, rsp_hit_d;

    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] first_inv;
    logic             any_hit;
    logic             any_inv;
    logic             cam_clear;
    logic             cam_wr;
    logic             victim_onehot;

    lru_tag_cam #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) u_cam (
        .clk      (clk),
        .rst      (rst),
        .clear_all(cam_clear),
        .wr_en    (cam_wr),
        .wr_blk   (alloc_q),
        .wr_tag   (tag_q),
        .cmp_tag  (tag_q),
        .hit_vec  (hit_vec),
        .any_hit  (any_hit),
        .first_inv(first_inv),
        .any_inv  (any_inv)
    );

    // The stack's victim is only trusted when it is a clean one-hot.
    assign victim_onehot = (lru_victim_blk != '0) &&
                           ((lru_victim_blk & (lru_victim_blk - DEPTH'(1))) == '0);

    // State and request context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tag_q     <= '0;
            alloc_q   <= '0;
            rsp_blk_q <= '0;
            rsp_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            alloc_q   <= alloc_d;
            rsp_blk_q <= rsp_blk_d;
            rsp_hit_q <= rsp_hit_d;
        end
    end

    // Next-state and output decode; outputs are zero unless their strobe is high.
    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        alloc_d          = alloc_q;
        rsp_blk_d        = rsp_blk_q;
        rsp_hit_d        = rsp_hit_q;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_hit          = 1'b0;
        rsp_blk          = '0;
        refill_req_valid = 1'b0;
        refill_req_tag   = '0;
        refill_req_blk   = '0;
        lru_update       = 1'b0;
        lru_accessed_blk = '0;
        cam_clear        = 1'b0;
        cam_wr           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (inv_all) begin
                    cam_clear = 1'b1;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        tag_d   = req_tag;
                        state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                if (any_hit) begin
                    lru_update       = 1'b1;
                    lru_accessed_blk = hit_vec;
                    rsp_hit_d        = 1'b1;
                    rsp_blk_d        = hit_vec;
                    state_d          = StResp;
                end else begin
                    if (any_inv) begin
                        alloc_d = first_inv;
                    end else if (victim_onehot) begin
                        alloc_d = lru_victim_blk;
                    end else begin
                        alloc_d = DEPTH'(1);
                    end
                    state_d = StRefill;
                end
            end
            StRefill: begin
                refill_req_valid = 1'b1;
                refill_req_tag   = tag_q;
                refill_req_blk   = alloc_q;
                if (refill_ack) begin
                    cam_wr           = 1'b1;
                    lru_update       = 1'b1;
                    lru_accessed_blk = alloc_q;
                    rsp_hit_d        = 1'b0;
                    rsp_blk_d        = alloc_q;
                    state_d          = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_hit   = rsp_hit_q;
                rsp_blk   = rsp_blk_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset abandons any request in flight: no strobes, no store updates.
        if (rst) begin
            req_ready        = 1'b0;
            rsp_valid        = 1'b0;
            rsp_hit          = 1'b0;
            rsp_blk          = '0;
            refill_req_valid = 1'b0;
            refill_req_tag   = '0;
            refill_req_blk   = '0;
            lru_update       = 1'b0;
            lru_accessed_blk = '0;
            cam_clear        = 1'b0;
            cam_wr           = 1'b0;
        end
    end

endmodule

// File: tb/tb_lru_tag_ctrl.sv
// Self-checking bench for lru_tag_ctrl: vector table, corner sequences, random traffic.
module tb_lru_tag_ctrl;

    localparam int D  = 8;
    localparam int TW = 20;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [TW-1:0] req_tag;
    logic          inv_all;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [D-1:0]  rsp_blk;
    logic          refill_req_valid;
    logic [TW-1:0] refill_req_tag;
    logic [D-1:0]  refill_req_blk;
    logic          refill_ack;
    logic          lru_update;
    logic [D-1:0]  lru_accessed_blk;
    logic [D-1:0]  lru_victim_blk;

    lru_tag_ctrl #(
        .DEPTH(D),
        .TAG_W(TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_tag         (req_tag),
        .inv_all         (inv_all),
        .rsp_valid       (rsp_valid),
        .rsp_hit         (rsp_hit),
        .rsp_blk         (rsp_blk),
        .refill_req_valid(refill_req_valid),
        .refill_req_tag  (refill_req_tag),
        .refill_req_blk  (refill_req_blk),
        .refill_ack      (refill_ack),
        .lru_update      (lru_update),
        .lru_accessed_blk(lru_accessed_blk),
        .lru_victim_blk  (lru_victim_blk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: entry contents plus recency order (front = least recent).
    logic          mvalid [D];
    logic [TW-1:0] mtag   [D];
    int            lru_q  [$];

    typedef struct {
        logic          hit;
        logic [D-1:0]  blk;
        int            rsp_cyc;
        int            lru_cnt;
        int            lru_cyc;
        logic [D-1:0]  lru_blk;
        int            refill_cnt;
        logic [TW-1:0] refill_tag;
        logic [D-1:0]  refill_blk;
        logic          refill_stable;
        logic          ready_low;
        logic          zero_ok;
        logic          done;
    } obs_t;

    typedef struct {
        logic [TW-1:0] tag;
        bit            use_ovr;
        logic [D-1:0]  ovr;
        int            d;
        bit            hit;
        logic [D-1:0]  blk;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [D-1:0] model_victim();
        logic [D-1:0] v;
        v = '0;
        if (lru_q.size() == D) v[lru_q[0]] = 1'b1;
        return v;
    endfunction

    function automatic void model_touch(input int idx);
        for (int k = 0; k < lru_q.size(); k++) begin
            if (lru_q[k] == idx) begin
                lru_q.delete(k);
                break;
            end
        end
        lru_q.push_back(idx);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) mvalid[i] = 1'b0;
        lru_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; req_tag = '0; inv_all = 1'b0;
        refill_ack = 1'b0; lru_victim_blk = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp", {rsp_valid, rsp_hit, rsp_blk}, 0);
        chk("rst_refill", {refill_req_valid, refill_req_tag, refill_req_blk}, 0);
        chk("rst_lru", {lru_update, lru_accessed_blk}, 0);
    endtask

    // Drives one request from IDLE to its response, acting as memory and recording what is seen.
    task automatic run_req(input logic [TW-1:0] tag, input int ack_delay, input bit hold_inv,
                           output obs_t o);
        o = '{hit: 0, blk: 0, rsp_cyc: 0, lru_cnt: 0, lru_cyc: 0, lru_blk: 0, refill_cnt: 0,
              refill_tag: 0, refill_blk: 0, refill_stable: 1, ready_low: 1, zero_ok: 1, done: 0};
        req_valid = 1'b1;
        req_tag   = tag;
        #1;
        chk("ready_at_issue", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_tag   = '0;
        for (int c = 1; c <= 60 && !o.done; c++) begin
            inv_all    = hold_inv;
            refill_ack = refill_req_valid && (o.refill_cnt >= ack_delay);
            #1;
            if (refill_req_valid) begin
                if (o.refill_cnt == 0) begin
                    o.refill_tag = refill_req_tag;
                    o.refill_blk = refill_req_blk;
                end else if (refill_req_tag != o.refill_tag || refill_req_blk != o.refill_blk) begin
                    o.refill_stable = 1'b0;
                end
                o.refill_cnt++;
            end else if (refill_req_tag != '0 || refill_req_blk != '0) begin
                o.zero_ok = 1'b0;
            end
            if (lru_update) begin
                o.lru_cnt++;
                o.lru_cyc = c;
                o.lru_blk = lru_accessed_blk;
            end else if (lru_accessed_blk != '0) begin
                o.zero_ok = 1'b0;
            end
            if (req_ready) o.ready_low = 1'b0;
            if (rsp_valid) begin
                o.done    = 1'b1;
                o.rsp_cyc = c;
                o.hit     = rsp_hit;
                o.blk     = rsp_blk;
            end else if (rsp_hit || rsp_blk != '0) begin
                o.zero_ok = 1'b0;
            end
            @(negedge clk);
        end
        refill_ack = 1'b0;
        inv_all    = 1'b0;
    endtask

    // Runs one request and checks every observable against the model, then updates the model.
    task automatic check_req(input logic [TW-1:0] tag, input int d, input bit hold_inv,
                             input bit use_ovr, input logic [D-1:0] ovr,
                             output bit got_hit, output logic [D-1:0] got_blk);
        obs_t         o;
        bit           exp_hit;
        int           idx;
        logic [D-1:0] vict;
        logic [D-1:0] exp_blk;

        vict           = use_ovr ? ovr : model_victim();
        lru_victim_blk = vict;
        exp_hit = 1'b0;
        idx     = -1;
        for (int i = 0; i < D; i++) begin
            if (mvalid[i] && mtag[i] == tag) begin
                exp_hit = 1'b1;
                idx     = i;
            end
        end
        if (!exp_hit) begin
            for (int i = D - 1; i >= 0; i--) if (!mvalid[i]) idx = i;
            if (idx < 0) begin
                idx = 0;
                if ($countones(vict) == 1) begin
                    for (int i = 0; i < D; i++) if (vict[i]) idx = i;
                end
            end
        end
        exp_blk = '0;
        exp_blk[idx] = 1'b1;

        run_req(tag, d, hold_inv, o);
        chk("rsp_timeout", o.done, 1);
        chk("rsp_hit", o.hit, exp_hit);
        chk("rsp_blk", o.blk, exp_blk);
        chk("lru_pulses", o.lru_cnt, 1);
        chk("lru_blk", o.lru_blk, exp_blk);
        chk("lru_cycle", o.lru_cyc, exp_hit ? 1 : 2 + d);
        chk("rsp_cycle", o.rsp_cyc, exp_hit ? 2 : 3 + d);
        chk("ready_low_busy", o.ready_low, 1);
        chk("idle_zero_outputs", o.zero_ok, 1);
        chk("refill_cycles", o.refill_cnt, exp_hit ? 0 : d + 1);
        if (!exp_hit) begin
            chk("refill_tag", o.refill_tag, tag);
            chk("refill_blk", o.refill_blk, exp_blk);
            chk("refill_stable", o.refill_stable, 1);
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
        end
        model_touch(idx);
        #1;
        chk("ready_after_rsp", req_ready, 1);
        got_hit = o.hit;
        got_blk = o.blk;
    endtask

    task automatic do_inv(input bit with_req, input logic [TW-1:0] tag);
        inv_all   = 1'b1;
        req_valid = with_req;
        req_tag   = tag;
        #1;
        chk("inv_ready_low", req_ready, 0);
        @(negedge clk);
        inv_all   = 1'b0;
        req_valid = 1'b0;
        req_tag   = '0;
        #1;
        chk("inv_not_accepted", {req_ready, lru_update, refill_req_valid, rsp_valid}, 4'b1000);
        for (int i = 0; i < D; i++) mvalid[i] = 1'b0;
    endtask

    initial begin
        bit           h;
        logic [D-1:0] b;

        for (int i = 0; i < D; i++) begin
            tbl[i] = '{TW'(32'h10 + i), 1'b0, '0, i % 3, 1'b0, D'(1) << i};
        end
        tbl[8]  = '{TW'(32'h13), 1'b0, 8'h00, 0, 1'b1, 8'h08};
        tbl[9]  = '{TW'(32'h99), 1'b1, 8'h04, 1, 1'b0, 8'h04};
        tbl[10] = '{TW'(32'h99), 1'b1, 8'h40, 0, 1'b1, 8'h04};
        tbl[11] = '{TW'(32'h12), 1'b1, 8'h20, 2, 1'b0, 8'h20};
        tbl[12] = '{TW'(32'h55), 1'b1, 8'h06, 0, 1'b0, 8'h01};
        tbl[13] = '{TW'(32'h10), 1'b1, 8'h00, 0, 1'b0, 8'h01};
        tbl[14] = '{TW'(32'h55), 1'b1, 8'h80, 1, 1'b0, 8'h80};
        tbl[15] = '{TW'(32'h14), 1'b0, 8'h00, 0, 1'b1, 8'h10};

        do_reset();

        // Cold misses, a hit, victim replacement, degenerate victim vectors.
        for (int i = 0; i < 16; i++) begin
            check_req(tbl[i].tag, tbl[i].d, 1'b0, tbl[i].use_ovr, tbl[i].ovr, h, b);
            chk($sformatf("tbl%0d_hit", i), h, tbl[i].hit);
            chk($sformatf("tbl%0d_blk", i), b, tbl[i].blk);
        end

        // Refill acknowledge held off for five cycles.
        check_req(TW'(32'hAB), 5, 1'b0, 1'b1, 8'h02, h, b);
        chk("stall_blk", b, 8'h02);

        // Bulk invalidate with a competing request, then allocation restarts at entry 0.
        do_inv(1'b1, TW'(32'h14));
        check_req(TW'(32'h14), 0, 1'b0, 1'b0, '0, h, b);
        chk("inv_first_alloc", {h, b}, {1'b0, 8'h01});
        check_req(TW'(32'h99), 1, 1'b0, 1'b0, '0, h, b);
        chk("inv_second_alloc", {h, b}, {1'b0, 8'h02});

        // inv_all raised while busy must leave the entries intact.
        check_req(TW'(32'h14), 0, 1'b1, 1'b0, '0, h, b);
        check_req(TW'(32'h99), 0, 1'b1, 1'b0, '0, h, b);
        chk("busy_inv_ignored", {h, b}, {1'b1, 8'h02});

        // Reset while waiting on a refill.
        lru_victim_blk = '0;
        req_valid = 1'b1;
        req_tag   = TW'(32'h3C);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rr_in_refill", refill_req_valid, 1);
        rst        = 1'b1;
        refill_ack = 1'b1;
        #1;
        chk("rr_strobes_in_rst", {lru_update, rsp_valid, refill_req_valid}, 0);
        @(negedge clk);
        rst        = 1'b0;
        refill_ack = 1'b0;
        model_reset();
        #1;
        chk("rr_ready_after", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rr_quiet", {rsp_valid, lru_update, refill_req_valid}, 0);
            @(negedge clk);
            #1;
        end
        check_req(TW'(32'h3C), 0, 1'b0, 1'b0, '0, h, b);
        chk("rr_realloc", {h, b}, {1'b0, 8'h01});

        // Random traffic over a small tag pool against the model.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 24) == 0) do_inv(1'b0, '0);
            check_req(TW'(32'h200 + $urandom_range(0, 11)), int'($urandom_range(0, 3)),
                      bit'($urandom_range(0, 7) == 0), 1'b0, '0, h, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lru_tag_ctrl.md
LRU_TAG_CTRL -- requirements
Module: lru_tag_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of fully-associative entries; all block vectors are one-hot of this width.
REQ-002 SHALL have parameter TAG_W, default 20: tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1: a lookup request is present.
REQ-006 SHALL have port req_ready, output, 1: lookup can be accepted.
REQ-007 SHALL have port req_tag, input, TAG_W: tag to look up.
REQ-008 SHALL have port inv_all, input, 1: invalidate all entries.
REQ-009 SHALL have port rsp_valid, output, 1: one-cycle response strobe.
REQ-010 SHALL have port rsp_hit, output, 1: response was a hit.
REQ-011 SHALL have port rsp_blk, output, DEPTH: one-hot entry hit or allocated.
REQ-012 SHALL have port refill_req_valid, output, 1: refill request to memory.
REQ-013 SHALL have port refill_req_tag, output, TAG_W: tag being refilled.
REQ-014 SHALL have port refill_req_blk, output, DEPTH: one-hot destination entry.
REQ-015 SHALL have port refill_ack, input, 1: memory accepted and completed the refill.
REQ-016 SHALL have port lru_update, output, 1: update strobe to the LRU stack.
REQ-017 SHALL have port lru_accessed_blk, output, DEPTH: one-hot entry to move to MRU.
REQ-018 SHALL have port lru_victim_blk, input, DEPTH: one-hot LRU victim from the stack; all-zero while the stack is not full.

Function
REQ-019 SHALL hold per entry a valid bit and a TAG_W tag register.
REQ-020 SHALL implement FSM states IDLE, LOOKUP, REFILL, RESP.
REQ-021 SHALL assert req_ready only in IDLE with inv_all low; accept on req_valid&req_ready, latch req_tag, go to LOOKUP.
REQ-022 SHALL, in IDLE with inv_all high, clear all valid bits in one cycle and accept no request that cycle.
REQ-023 SHALL, in LOOKUP, compare the latched tag against all valid entries (invalid entries never hit).
REQ-024 SHALL, on a LOOKUP hit, assert lru_update for that cycle with lru_accessed_blk = hit one-hot, then go to RESP with rsp_hit=1.
REQ-025 SHALL, on a LOOKUP miss, select alloc_blk: lowest-index invalid entry if any; else lru_victim_blk if exactly one-hot; else entry 0. Register it, go to REFILL.
REQ-026 SHALL, in REFILL, hold refill_req_valid high with stable refill_req_tag/refill_req_blk until the cycle refill_ack is sampled high.
REQ-027 SHALL ignore refill_ack outside REFILL.
REQ-028 SHALL, in the refill_ack cycle, write the tag, set valid for alloc_blk, pulse lru_update with lru_accessed_blk = alloc_blk, and go to RESP with rsp_hit=0.
REQ-029 SHALL, in RESP, assert rsp_valid for exactly one cycle with rsp_hit and rsp_blk, then return to IDLE.
REQ-030 SHALL give hit latency: accept cycle T, lru_update T+1, rsp_valid T+2; miss: lru_update in ack cycle A, rsp_valid A+1.
REQ-031 SHALL hold lru_update low in every cycle not covered by REQ-024 or REQ-028 (exactly one pulse per request).
REQ-032 SHALL drive rsp_blk, refill_req_blk, lru_accessed_blk and refill_req_tag to zero when their strobe is low.
REQ-033 SHALL ignore inv_all outside IDLE; it remains asserted to the IDLE return if the source holds it.

Reset
REQ-034 SHALL, on rst, enter IDLE, clear all valid bits, and drive every output to 0 except req_ready, which is 1 in the first cycle after reset.
REQ-035 SHALL, on rst mid-operation (LOOKUP/REFILL/RESP), abandon the request with no rsp_valid and no lru_update; tag registers need no reset.

Structure
REQ-036 SHALL take DEPTH, TAG_W defaults and the state enum from shared package lru_pkg.
REQ-037 SHALL place the tag/valid store and parallel compare in sub-module lru_tag_cam (outputs one-hot hit vector, any-hit, first-invalid one-hot).

Verification
REQ-038 SHALL cover cold misses: after reset, tags 0x10..0x17 -> refills to blk 0x01..0x80 in order, rsp_hit=0, lru_update once each.
REQ-039 SHALL cover hit: after REQ-038, tag 0x13 -> lru_update at T+1 with 0x08, rsp_valid T+2, rsp_hit=1, rsp_blk=0x08, no refill.
REQ-040 SHALL cover victim: full array, lru_victim_blk=0x04, tag 0x99 -> refill_req_blk=0x04, refill_req_tag=0x99; later 0x99 hits at 0x04, old tag misses.
REQ-041 SHALL cover ack stall: refill_ack delayed 5 cycles -> refill_req_valid/tag/blk stable 5 cycles, req_ready low throughout.
REQ-042 SHALL cover inv_all in IDLE -> all subsequent lookups miss, allocation restarts at 0x01.
REQ-043 SHALL cover rst asserted in REFILL -> no rsp_valid, no lru_update, IDLE with req_ready=1 next cycle.
